// File: rtl/multdiv_sequencer_if.sv
// multdiv_sequencer_if: bundles the issue, multdiv-unit and writeback signals of the
// multiply/divide sequencer.
//   slave  : sequencer view (consumes issue_* and md_result*, drives ctrl/stall/wb).
//   master : environment view (execute stage + multdiv unit + writeback).
// Ports: none; the DATA_WIDTH parameter sizes the operand and result buses.
interface multdiv_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    // Issue side (decode/execute)
    logic                  issue_valid;
    logic                  issue_is_mul;
    logic                  issue_is_div;
    logic [DATA_WIDTH-1:0] issue_a;
    logic [DATA_WIDTH-1:0] issue_b;
    logic [4:0]            issue_rd;
    // Multdiv unit
    logic                  md_result_rdy;
    logic                  md_exception;
    logic [DATA_WIDTH-1:0] md_result;
    logic                  ctrl_mult;
    logic                  ctrl_div;
    logic [DATA_WIDTH-1:0] md_a;
    logic [DATA_WIDTH-1:0] md_b;
    // Pipeline control and writeback
    logic                  stall;
    logic                  busy;
    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_exception;

    modport slave (
        input  issue_valid, issue_is_mul, issue_is_div, issue_a, issue_b, issue_rd,
        input  md_result_rdy, md_exception, md_result,
        output ctrl_mult, ctrl_div, md_a, md_b,
        output stall, busy, wb_valid, wb_rd, wb_data, wb_exception
    );

    modport master (
        output issue_valid, issue_is_mul, issue_is_div, issue_a, issue_b, issue_rd,
        output md_result_rdy, md_exception, md_result,
        input  ctrl_mult, ctrl_div, md_a, md_b,
        input  stall, busy, wb_valid, wb_rd, wb_data, wb_exception
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: drives the multi-cycle multiplier/divider for R-type MUL/DIV ops.
// Latches operands and destination, pulses the unit's start control for one cycle,
// stalls the pipeline until the result is ready, then presents a single writeback beat.
// Exceptions from the unit are redirected to the rstatus register with an op-specific code.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : multdiv_sequencer_if.slave (issue inputs, multdiv handshake, stall/busy, writeback)
// Optional feature: define MULTDIV_TIMEOUT_EN to force an exception writeback when the
// unit has not answered after TIMEOUT_CYCLES cycles of waiting.
module multdiv_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
`ifdef MULTDIV_TIMEOUT_EN
    parameter int unsigned CNT_WIDTH      = 7,
    parameter int unsigned TIMEOUT_CYCLES = 64,
`endif
    parameter int unsigned RSTATUS_REG    = 30,
    parameter int unsigned MUL_EXC_CODE   = 4,
    parameter int unsigned DIV_EXC_CODE   = 5
) (
    input logic                 clock,
    input logic                 reset,
    multdiv_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic                  op_mul_q, op_mul_d;  // 1: multiply, 0: divide
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [4:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  exc_q, exc_d;
`ifdef MULTDIV_TIMEOUT_EN
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
`endif

    logic accept;

    // Exactly one op flag must be set; ambiguous or empty decodes are left alone.
    assign accept = (state_q == StIdle) & bus.issue_valid & (bus.issue_is_mul ^ bus.issue_is_div);

    always_comb begin
        state_d  = state_q;
        op_mul_d = op_mul_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        res_d    = res_q;
        exc_d    = exc_q;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_mul_d = bus.issue_is_mul;
                    a_d      = bus.issue_a;
                    b_d      = bus.issue_b;
                    rd_d     = bus.issue_rd;
                    state_d  = StStart;
                end
            end
            StStart: begin
`ifdef MULTDIV_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
`ifdef MULTDIV_TIMEOUT_EN
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
                // A ready result takes priority over a coincident timeout.
                if (bus.md_result_rdy) begin
                    res_d   = bus.md_result;
                    exc_d   = bus.md_exception;
                    state_d = StDone;
                end
`ifdef MULTDIV_TIMEOUT_EN
                else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
                    exc_d   = 1'b1;
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            op_mul_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            res_q    <= '0;
            exc_q    <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_mul_q <= op_mul_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_q     <= rd_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.ctrl_mult = (state_q == StStart) & op_mul_q;
    assign bus.ctrl_div  = (state_q == StStart) & ~op_mul_q;
    assign bus.md_a      = a_q;
    assign bus.md_b      = b_q;

    // Stall starts combinationally in the accept cycle; DONE releases the pipeline.
    assign bus.stall     = accept | (state_q == StStart) | (state_q == StWait);
    assign bus.busy      = (state_q != StIdle);

    assign bus.wb_valid     = (state_q == StDone);
    assign bus.wb_exception = exc_q;
    assign bus.wb_rd        = exc_q ? 5'(RSTATUS_REG) : rd_q;
    assign bus.wb_data      = !exc_q  ? res_q :
                              op_mul_q ? DATA_WIDTH'(MUL_EXC_CODE) : DATA_WIDTH'(DIV_EXC_CODE);

endmodule
